countdown_timer_modulo_k: RTL and testbench

Loadable down-counter: takes a start value, counts down to zero at a prescaled tick rate, and emits a one-cycle terminal pulse. It is the countdown partner of the free-running modulo-k up-counter. Use it for board-level delays and timeouts, with keys and LEDs driving it directly in the board wrapper.

---
 rtl/counter_pkg.sv | 26 ++
 rtl/tick_prescaler.sv | 47 ++++
 rtl/countdown_timer_modulo_k.sv | 130 +++++++++++++
 tb/tb_countdown_timer_modulo_k.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: the width helper and the countdown FSM states.
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

   // Number of bits needed to hold value; never less than one.
   function automatic int clogb2(input int value);
      int bits;
      int v;
      bits = 0;
      v    = value;
      while (v > 0) begin
         bits = bits + 1;
         v    = v >>> 1;
      end
      if (bits < 1) begin
         bits = 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE; tick is high on the last enabled cycle of each group.
module tick_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic aclr,
   input  logic clear,
   input  logic count_en,
   output logic tick
);

   localparam int            CW   = clogb2(PRESCALE - 1);
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // With PRESCALE=1 LAST is zero and count_q never leaves zero, so tick follows count_en.
   assign tick = count_en && (count_q == LAST);

   // Prescaler next-state: clear wins, then wrap on tick, else advance while enabled.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = {CW{1'b0}};
      end else if (tick) begin
         count_d = {CW{1'b0}};
      end else if (count_en) begin
         count_d = count_q + ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Prescaler count register.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         count_q <= {CW{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/countdown_timer_modulo_k.sv
// Loadable prescaled down-counter with one-cycle terminal pulse.
// Define COUNTDOWN_AUTORELOAD_EN to reload the start value on each terminal event.
module countdown_timer_modulo_k
   import counter_pkg::*;
#(
   parameter  int M        = 20,
   parameter  int PRESCALE = 1,
   localparam int N        = clogb2(M - 1)
) (
   input  logic         clk,
   input  logic         aclr,
   input  logic         enable,
   input  logic         load,
   input  logic [N-1:0] load_value,
   output logic [N-1:0] Q,
   output logic         zero,
   output logic         busy
);

   localparam logic [N-1:0] MAX_VAL = N'(M - 1);
   localparam logic [N-1:0] ONE     = N'(1);

   state_e       state_q, state_d;
   logic [N-1:0] q_q, q_d;
   logic         zero_q, zero_d;
   logic         busy_q, busy_d;
   logic [N-1:0] start_s;
   logic         tick_s;
`ifdef COUNTDOWN_AUTORELOAD_EN
   logic [N-1:0] reload_q, reload_d;
`endif

   assign start_s = (load_value > MAX_VAL) ? MAX_VAL : load_value;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk      (clk),
      .aclr     (aclr),
      .clear    (load),
      .count_en ((state_q == RUN) && enable),
      .tick     (tick_s)
   );

   // FSM next-state, count and pulse logic; load overrides everything else.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      zero_d  = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_d = reload_q;
`endif
      if (load) begin
         q_d     = start_s;
         state_d = (start_s != {N{1'b0}}) ? RUN : IDLE;
`ifdef COUNTDOWN_AUTORELOAD_EN
         reload_d = start_s;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            RUN: begin
               if (!enable) begin
                  state_d = PAUSE;
               end else if (tick_s) begin
                  // Q==0 cannot be reached in RUN; treating it as terminal stops any underflow.
                  if (q_q > ONE) begin
                     q_d = q_q - ONE;
                  end else begin
                     zero_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                     q_d     = reload_q;
                     state_d = RUN;
`else
                     q_d     = {N{1'b0}};
                     state_d = IDLE;
`endif
                  end
               end else begin
                  state_d = RUN;
               end
            end
            PAUSE: begin
               if (enable) begin
                  state_d = RUN;
               end else begin
                  state_d = PAUSE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         state_q <= IDLE;
         q_q     <= {N{1'b0}};
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         zero_q  <= zero_d;
         busy_q  <= busy_d;
      end
   end

`ifdef COUNTDOWN_AUTORELOAD_EN
   // Reload register holding the last loaded start value.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         reload_q <= {N{1'b0}};
      end else begin
         reload_q <= reload_d;
      end
   end
`endif

   assign Q    = q_q;
   assign zero = zero_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_countdown_timer_modulo_k.sv
// Directed bench: vector table plus hand sequences for prescale, pause, reset and autoreload.
module tb_countdown_timer_modulo_k;

   logic       clk;
   logic       aclr;
   logic       a_en, a_ld;
   logic [4:0] a_lv, a_q;
   logic       a_z, a_b;
   logic       b_en, b_ld;
   logic [4:0] b_lv, b_q;
   logic       b_z, b_b;

   int checks;
   int errors;

   typedef struct {
      logic       ld;
      logic       en;
      logic [4:0] lv;
      logic [4:0] q;
      logic       z;
      logic       b;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs[NV];

   countdown_timer_modulo_k #(.M(20), .PRESCALE(1)) dut_a (
      .clk(clk), .aclr(aclr), .enable(a_en), .load(a_ld),
      .load_value(a_lv), .Q(a_q), .zero(a_z), .busy(a_b)
   );

   countdown_timer_modulo_k #(.M(20), .PRESCALE(3)) dut_b (
      .clk(clk), .aclr(aclr), .enable(b_en), .load(b_ld),
      .load_value(b_lv), .Q(b_q), .zero(b_z), .busy(b_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step_a(input logic ld, input logic en, input logic [4:0] lv);
      a_ld = ld;
      a_en = en;
      a_lv = lv;
      @(posedge clk);
      #1;
      a_ld = 1'b0;
   endtask

   task automatic chk_a(input string name, input logic [4:0] q, input logic z, input logic b);
      chk({name, ".Q"}, {3'd0, a_q}, {3'd0, q});
      chk({name, ".zero"}, {7'd0, a_z}, {7'd0, z});
      chk({name, ".busy"}, {7'd0, a_b}, {7'd0, b});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      aclr = 1'b0;
      a_en = 1'b0; a_ld = 1'b0; a_lv = 5'd0;
      b_en = 1'b0; b_ld = 1'b0; b_lv = 5'd0;

      //          ld    en    lv      Q      zero  busy
      vecs[0]  = '{1'b1, 1'b1, 5'd5,  5'd5,  1'b0, 1'b1};
      vecs[1]  = '{1'b0, 1'b1, 5'd0,  5'd4,  1'b0, 1'b1};
      vecs[2]  = '{1'b0, 1'b1, 5'd0,  5'd3,  1'b0, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 5'd0,  5'd2,  1'b0, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 5'd0,  5'd1,  1'b0, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 5'd0,  5'd0,  1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 5'd0,  5'd0,  1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 5'd0,  5'd0,  1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 5'd6,  5'd6,  1'b0, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 5'd0,  5'd5,  1'b0, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 5'd0,  5'd4,  1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 5'd0,  5'd3,  1'b0, 1'b1};
      vecs[13] = '{1'b1, 1'b1, 5'd7,  5'd7,  1'b0, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 5'd0,  5'd6,  1'b0, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 5'd3,  5'd3,  1'b0, 1'b1};
      vecs[16] = '{1'b0, 1'b0, 5'd0,  5'd3,  1'b0, 1'b1};
      vecs[17] = '{1'b0, 1'b1, 5'd0,  5'd3,  1'b0, 1'b1};
      vecs[18] = '{1'b0, 1'b1, 5'd0,  5'd2,  1'b0, 1'b1};
      vecs[19] = '{1'b1, 1'b1, 5'd1,  5'd1,  1'b0, 1'b1};
      vecs[20] = '{1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 1'b0};
      vecs[21] = '{1'b0, 1'b1, 5'd0,  5'd0,  1'b0, 1'b0};
      vecs[22] = '{1'b1, 1'b1, 5'd31, 5'd19, 1'b0, 1'b1};
      vecs[23] = '{1'b1, 1'b1, 5'd20, 5'd19, 1'b0, 1'b1};
      vecs[24] = '{1'b1, 1'b1, 5'd25, 5'd19, 1'b0, 1'b1};

      #12;
      chk_a("reset_a", 5'd0, 1'b0, 1'b0);
      chk("reset_b.Q", {3'd0, b_q}, 8'd0);
      chk("reset_b.busy", {7'd0, b_b}, 8'd0);
      @(negedge clk);
      aclr = 1'b1;
      @(posedge clk);
      #1;

`ifdef COUNTDOWN_AUTORELOAD_EN
      step_a(1'b1, 1'b1, 5'd3);
      chk_a("ar_load", 5'd3, 1'b0, 1'b1);
      for (int r = 0; r < 2; r++) begin
         step_a(1'b0, 1'b1, 5'd0);
         chk_a("ar_q2", 5'd2, 1'b0, 1'b1);
         step_a(1'b0, 1'b1, 5'd0);
         chk_a("ar_q1", 5'd1, 1'b0, 1'b1);
         step_a(1'b0, 1'b1, 5'd0);
         chk_a("ar_reload", 5'd3, 1'b1, 1'b1);
      end
`else
      for (int i = 0; i < NV; i++) begin
         step_a(vecs[i].ld, vecs[i].en, vecs[i].lv);
         chk_a($sformatf("vec%0d", i), vecs[i].q, vecs[i].z, vecs[i].b);
      end

      // Clamped load of 19 from the last vector: zero 19 cycles after the load edge.
      for (int k = 18; k >= 1; k--) begin
         step_a(1'b0, 1'b1, 5'd0);
         chk_a("clamp_run", 5'(k), 1'b0, 1'b1);
      end
      step_a(1'b0, 1'b1, 5'd0);
      chk_a("clamp_zero", 5'd0, 1'b1, 1'b0);

      // Pause with Q=2 for 10 cycles, then resume.
      step_a(1'b1, 1'b1, 5'd4);
      step_a(1'b0, 1'b1, 5'd0);
      step_a(1'b0, 1'b1, 5'd0);
      chk_a("pause_pre", 5'd2, 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         step_a(1'b0, 1'b0, 5'd0);
         chk_a("pause_hold", 5'd2, 1'b0, 1'b1);
      end
      step_a(1'b0, 1'b1, 5'd0);
      chk_a("resume0", 5'd2, 1'b0, 1'b1);
      step_a(1'b0, 1'b1, 5'd0);
      chk_a("resume1", 5'd1, 1'b0, 1'b1);
      step_a(1'b0, 1'b1, 5'd0);
      chk_a("resume_zero", 5'd0, 1'b1, 1'b0);

      // Prescale 3 on the second instance: each value held 3 cycles, zero after 6.
      b_ld = 1'b1; b_en = 1'b1; b_lv = 5'd2;
      @(posedge clk);
      #1;
      b_ld = 1'b0;
      chk("ps_load.Q", {3'd0, b_q}, 8'd2);
      chk("ps_load.busy", {7'd0, b_b}, 8'd1);
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("ps_c%0d.Q", c), {3'd0, b_q}, (c < 3) ? 8'd2 : ((c < 6) ? 8'd1 : 8'd0));
         chk($sformatf("ps_c%0d.zero", c), {7'd0, b_z}, (c == 6) ? 8'd1 : 8'd0);
      end
      b_en = 1'b0;
`endif

      // Asynchronous reset mid-count clears at once and the count does not resume.
      step_a(1'b1, 1'b1, 5'd6);
      step_a(1'b0, 1'b1, 5'd0);
      step_a(1'b0, 1'b1, 5'd0);
      chk_a("pre_reset", 5'd4, 1'b0, 1'b1);
      #2;
      aclr = 1'b0;
      #1;
      chk_a("async_reset", 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      aclr = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step_a(1'b0, 1'b1, 5'd0);
         chk_a("post_reset", 5'd0, 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
